des_decrypt_iter: RTL and testbench

Iterative single-block DES decryption engine: accepts a 64-bit ciphertext and 64-bit key over a valid/ready handshake and runs the 16 Feistel rounds one per clock, with the key schedule walked in reverse by right-rotating C/D. It produces the 64-bit plaintext over a second valid/ready handshake. It is the receive-side counterpart of the combinational DES encryption datapath, trading throughput for a single round instance.

---
 rtl/des_pkg.sv | 152 +++++++++++++++
 rtl/des_dec_f.sv | 26 ++
 rtl/des_decrypt_iter.sv | 155 +++++++++++++++
 tb/tb_des_decrypt_iter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES tables, widths, FSM state type and permutation helpers for the
// iterative decryption engine (des_decrypt_iter, des_dec_f).
package des_pkg;

  localparam int unsigned BLK_W    = 64;
  localparam int unsigned KEY_W    = 56;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned HALF_W   = 32;
  localparam int unsigned CD_W     = 28;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  typedef struct packed {
    logic [CD_W-1:0] c;
    logic [CD_W-1:0] d;
  } cd_t;

  // Table entries are 1-based DES bit numbers, bit 1 being the MSB.
  localparam int unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9,  1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25};

  localparam int unsigned E_TBL [48] = '{
    32, 1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
    8,  9,  10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32, 1};

  localparam int unsigned P_TBL [32] = '{
    16, 7,  20, 21, 29, 12, 28, 17,  1,  15, 23, 26, 5,  18, 31, 10,
    2,  8,  24, 14, 32, 27, 3,  9,   19, 13, 30, 6,  22, 11, 4,  25};

  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17, 9,   1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27,  19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29,  21, 13, 5,  28, 20, 12, 4};

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24, 1,  5,   3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,   16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Each S-box is row-major: index = row*16 + col.
  localparam int unsigned SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Right-rotate amount for decrypt round cnt+1 (reverse of encrypt left shifts).
  localparam int unsigned ROT_AMT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [BLK_W-1:0] ip_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] fp_perm(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[i])];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] pc1_perm(input logic [BLK_W-1:0] x);
    logic [KEY_W-1:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[i])];
    return y;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2_perm(input logic [KEY_W-1:0] x);
    logic [SUBKEY_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[i])];
    return y;
  endfunction

  function automatic logic [SUBKEY_W-1:0] e_expand(input logic [HALF_W-1:0] x);
    logic [SUBKEY_W-1:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[i])];
    return y;
  endfunction

  function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] x);
    logic [HALF_W-1:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[i])];
    return y;
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[0], x[CD_W-1:1]};
      2'd2:    return {x[1:0], x[CD_W-1:2]};
      default: return x;
    endcase
  endfunction

  // DES keys use odd parity per byte; flag any byte that fails it.
  function automatic logic key_parity_bad(input logic [BLK_W-1:0] k);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (~^k[b*8 +: 8]) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/des_dec_f.sv
// DES round function f(R, K) = P(S(E(R) ^ K)), purely combinational.
module des_dec_f
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   r_i,
  input  logic [SUBKEY_W-1:0] k_i,
  output logic [HALF_W-1:0]   f_c
);

  logic [SUBKEY_W-1:0] x;
  logic [HALF_W-1:0]   s;
  logic [5:0]          six;

  // Outer bits of each 6-bit group select the row, inner four the column.
  always_comb begin
    x   = e_expand(r_i) ^ k_i;
    s   = '0;
    six = '0;
    for (int k = 0; k < 8; k++) begin
      six = x[47 - 6*k -: 6];
      s[31 - 4*k -: 4] = 4'(SBOX[k][{six[5], six[0], six[4:1]}]);
    end
    f_c = p_perm(s);
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption, one Feistel round per clock with a reverse key walk.
// Optional key parity checking is enabled by defining DES_DEC_PARITY_CHK_EN.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [BLK_W-1:0] CIPHER_TEXT,
  input  logic [BLK_W-1:0] KEY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
`ifdef DES_DEC_PARITY_CHK_EN
  output logic             KEY_PARITY_ERR,
`endif
  output logic [BLK_W-1:0] PLAIN_TEXT
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HALF_W-1:0]   l_q, l_d, r_q, r_d;
  logic [CD_W-1:0]     key_c_q, key_c_d, key_d_q, key_d_d;
  logic [BLK_W-1:0]    pt_q, pt_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
`ifdef DES_DEC_PARITY_CHK_EN
  logic                perr_flag_q, perr_flag_d;
  logic                kpe_q, kpe_d;
`endif

  logic [1:0]          rot_amt;
  logic [CD_W-1:0]     c_rot, d_rot;
  logic [SUBKEY_W-1:0] subkey;
  logic [HALF_W-1:0]   f_out;
  logic [HALF_W-1:0]   r_new;
  logic [BLK_W-1:0]    ip_ct;
  cd_t                 pc1_key;

  // Round datapath: rotate C/D right, pick subkey, run f.
  always_comb begin
    rot_amt = 2'(ROT_AMT[cnt_q]);
    c_rot   = rotr28(key_c_q, rot_amt);
    d_rot   = rotr28(key_d_q, rot_amt);
    subkey  = pc2_perm({c_rot, d_rot});
    r_new   = l_q ^ f_out;
    ip_ct   = ip_perm(CIPHER_TEXT);
    pc1_key = cd_t'(pc1_perm(KEY));
  end

  des_dec_f u_f (
    .r_i (r_q),
    .k_i (subkey),
    .f_c (f_out)
  );

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    l_d         = l_q;
    r_d         = r_q;
    key_c_d     = key_c_q;
    key_d_d     = key_d_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
`ifdef DES_DEC_PARITY_CHK_EN
    perr_flag_d = perr_flag_q;
    kpe_d       = kpe_q;
`endif
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          l_d     = ip_ct[BLK_W-1:HALF_W];
          r_d     = ip_ct[HALF_W-1:0];
          key_c_d = pc1_key.c;
          key_d_d = pc1_key.d;
          cnt_d   = '0;
          state_d = ROUND;
`ifdef DES_DEC_PARITY_CHK_EN
          perr_flag_d = key_parity_bad(KEY);
`endif
        end
      end
      ROUND: begin
        key_c_d = c_rot;
        key_d_d = d_rot;
        l_d     = r_q;
        r_d     = r_new;
        if (cnt_q == CNT_W'(15)) begin
          // Final round: undo the L/R swap before the inverse permutation.
          pt_d        = fp_perm({r_new, r_q});
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef DES_DEC_PARITY_CHK_EN
          kpe_d       = perr_flag_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef DES_DEC_PARITY_CHK_EN
          kpe_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      key_c_q     <= '0;
      key_d_q     <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef DES_DEC_PARITY_CHK_EN
      perr_flag_q <= 1'b0;
      kpe_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      r_q         <= r_d;
      key_c_q     <= key_c_d;
      key_d_q     <= key_d_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef DES_DEC_PARITY_CHK_EN
      perr_flag_q <= perr_flag_d;
      kpe_q       <= kpe_d;
`endif
    end
  end

  assign IN_READY   = in_ready_q;
  assign OUT_VALID  = out_valid_q;
  assign PLAIN_TEXT = pt_q;
`ifdef DES_DEC_PARITY_CHK_EN
  assign KEY_PARITY_ERR = kpe_q;
`endif

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Scoreboard bench for des_decrypt_iter: directed known-answer DES vectors.
module tb_des_decrypt_iter;

  typedef struct {
    logic [63:0] pt;
    logic        perr;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] cipher_text;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plain_text;
  logic        kpe;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  logic ov_prev  = 1'b0;
  exp_t sb_q[$];

  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_B  = 64'h0000000000000000;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT_B  = 64'h8787878787878787;
  localparam logic [63:0] KEY_P = 64'h123457799BBCDFF1;

  des_decrypt_iter dut (
    .CLK            (clk),
    .RST_N          (rst_n),
    .IN_VALID       (in_valid),
    .IN_READY       (in_ready),
    .CIPHER_TEXT    (cipher_text),
    .KEY            (key),
    .OUT_VALID      (out_valid),
    .OUT_READY      (out_ready),
`ifdef DES_DEC_PARITY_CHK_EN
    .KEY_PARITY_ERR (kpe),
`endif
    .PLAIN_TEXT     (plain_text)
  );

`ifndef DES_DEC_PARITY_CHK_EN
  assign kpe = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: latency on first valid cycle, data compare on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !ov_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", plain_text);
      end else begin
        chk("latency", 64'(cyc - sb_q[0].acc), 64'd16);
      end
    end
    if (out_valid && out_ready && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("plain_text", plain_text, e.pt);
`ifdef DES_DEC_PARITY_CHK_EN
      chk("key_parity_err", 64'(kpe), 64'(e.perr));
`endif
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [63:0] ct, input logic [63:0] k,
                      input logic [63:0] exp_pt, input logic exp_perr);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid    = 1'b1;
    cipher_text = ct;
    key         = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.pt     = exp_pt;
    e.perr   = exp_perr;
    e.acc    = cyc;
    last_acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc1;
    int n;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    cipher_text = '0;
    key         = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_plain_text", plain_text, 64'd0);
    chk("reset_kpe", 64'(kpe), 64'd0);

    // Known-answer vectors.
    send(CT_A, KEY_A, PT_A, 1'b0);
    wait_drain();
    send(CT_B, KEY_B, PT_B, 1'b0);
    wait_drain();

    // Output stall with OUT_READY low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(CT_A, KEY_A, PT_A, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_plain_text", plain_text, PT_A);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    wait_drain();

    // Back-to-back period.
    send(CT_B, KEY_B, PT_B, 1'b0);
    acc1 = last_acc;
    send(CT_A, KEY_A, PT_A, 1'b0);
    chk("block_period", 64'(last_acc - acc1), 64'd18);
    wait_drain();

    // Input changes during ROUND are ignored.
    send(CT_A, KEY_A, PT_A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    in_valid    = 1'b1;
    cipher_text = CT_B;
    key         = KEY_B;
    @(negedge clk);
    chk("round_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();

    // Reset during round 8 discards the block.
    send(CT_B, KEY_B, PT_B, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_plain_text", plain_text, 64'd0);
    chk("midrst_kpe", 64'(kpe), 64'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_output", 64'(out_valid), 64'd0);
    send(CT_A, KEY_A, PT_A, 1'b0);
    wait_drain();

    // Key with an even-parity byte still decrypts correctly.
    send(CT_A, KEY_P, PT_A, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    chk("idle_kpe", 64'(kpe), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
